ntt_stage_ctrl: RTL and testbench
=================================

# ntt_stage_ctrl

Sequencing controller for one streaming NTT butterfly stage. It accepts a frame of coefficient pairs under a valid/ready handshake and drives the twiddle-factor index into the butterfly in the same cycle as each pair. It tracks the butterfly's fixed pipeline latency so that `out_valid`/`out_last` line up with the butterfly outputs, and reports completion with a `done` pulse. It replaces free-running counter/enable twiddle sequencing, so stalls in the input stream no longer misalign factors.

## Interface
- `N_PAIRS`, 256: coefficient pairs per frame (≥2).
- `TW_COUNT`, 8: distinct twiddle factors per stage (≥2); `tw_idx` wraps modulo this.
- `TW_REPEAT`, 1: accepted pairs per twiddle before `tw_idx` advances (≥1).
- `TW_START`, 0: `tw_idx` value for the first pair of every frame (< `TW_COUNT`).
- `BF_LAT`, 8: butterfly latency in cycles, from `y_in`/`w` sampled to `x_out`/`y_out` valid (≥1).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; asynchronous assert, active-low; deassertion synchronous to `clk` upstream.
- `start`  in  1  one-cycle frame request; honoured only in IDLE.
- `busy`  out  1  high in RUN, DRAIN and DONE.
- `in_valid`  in  1  source has a pair on the butterfly inputs this cycle.
- `in_ready`  out  1  high only in RUN; a pair is accepted when `in_valid & in_ready`.
- `tw_idx`  out  $clog2(TW_COUNT)  twiddle select for the butterfly; combinationally valid in the acceptance cycle.
- `out_valid`  out  1  butterfly outputs hold a result of an accepted pair.
- `out_last`  out  1  qualifies `out_valid` for the frame's final pair.
- `done`  out  1  one-cycle pulse when the frame has fully drained.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on `start`. Load `pair_cnt` = 0, `rep_cnt` = 0, `tw_idx` = `TW_START`.
- RUN: `in_ready` = 1. On each accept:
  - `pair_cnt`++.
  - `rep_cnt`++; when `rep_cnt` reaches `TW_REPEAT`−1 it clears and `tw_idx` = (`tw_idx`+1) mod `TW_COUNT`.
  - Wrap at any `TW_COUNT`, including non-power-of-two values.
- Cycles without an accept (stall) change no counter and leave `tw_idx` held.
- The accept with `pair_cnt` = `N_PAIRS`−1 moves RUN → DRAIN.
- Valid tracking: `BF_LAT`-deep shift register of {valid, last}, shifted every cycle.
  - Input bit is 1 on accept; last = 1 on the final accept.
  - `out_valid`/`out_last` are the tail bits.
- DRAIN: `in_ready` = 0. Stay until the shift register holds no valid bit and the tail has just emitted `out_last`, then go to DONE.
- DONE: `done` = 1 for exactly one cycle, then IDLE.
- `start` in RUN/DRAIN/DONE is ignored. `in_valid` outside RUN is ignored.
- Reset (`rst` low), including mid-frame: state IDLE, all counters 0, `tw_idx` = `TW_START`, shift register cleared.
  - Every output reads 0 except `tw_idx`.
  - No `done` is ever produced for an aborted frame.

## Timing
- Accept at cycle t → `out_valid` at cycle t+`BF_LAT`. Stalls propagate as `out_valid` = 0 gaps of equal length.
- Final accept at cycle t:
  - DRAIN from t+1.
  - `out_last` at t+`BF_LAT`.
  - DONE/`done` at t+`BF_LAT`+1.
  - IDLE at t+`BF_LAT`+2.
- `start` sampled at cycle s → `in_ready` = 1 from s+1. The minimum frame period is `N_PAIRS`+`BF_LAT`+2 cycles.
- `start` held high through `done` launches the next frame from the IDLE cycle. No overlap of frames.
- `tw_idx`, `in_ready` and `busy` come from registers. `out_valid`, `out_last` and `done` are registered.

## Test plan
- Reset values: hold `rst` low with random inputs → `busy`=`in_ready`=`out_valid`=`out_last`=`done`=0, `tw_idx`=0. Release, pulse `start` → `in_ready`=1 on the next cycle.
- Back-to-back frame, defaults: `in_valid` constantly 1 for 256 accepts.
  - `tw_idx` sequence is 0,1,…,7,0,….
  - `out_valid` goes high exactly 8 cycles after the first accept and stays high 256 cycles.
  - `out_last` is on the 256th; `done` comes one cycle later.
- Stalls: N_PAIRS=16, TW_REPEAT=2, TW_START=3, with `in_valid` toggling 1,0,0,1,….
  - Per-accept `tw_idx` sequence is 3,3,4,4,5,5,6,6,7,7,0,0,1,1,2,2.
  - `out_valid` pattern equals the accept pattern delayed 8 cycles.
- Non-power-of-two wrap: TW_COUNT=6 with 12 accepts → `tw_idx` 0..5,0..5. `start` pulses during RUN and DRAIN cause no change.
- Reset mid-operation: assert `rst` at accept 100 of 256 and again during DRAIN → immediate IDLE with outputs 0 and no `done`. A new `start` gives a clean frame with `tw_idx` beginning at `TW_START`.

Source files
------------

// File: rtl/ntt_stage_ctrl.sv
// ntt_stage_ctrl: twiddle sequencing and latency tracking for one NTT butterfly stage.
// Ports: clk, rst (async active-low), start, in_valid in; busy, in_ready, tw_idx, out_valid, out_last, done out.
module ntt_stage_ctrl #(
   parameter int N_PAIRS   = 256,
   parameter int TW_COUNT  = 8,
   parameter int TW_REPEAT = 1,
   parameter int TW_START  = 0,
   parameter int BF_LAT    = 8,
   localparam int TW_W     = $clog2(TW_COUNT)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            busy,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [TW_W-1:0] tw_idx,
   output logic            out_valid,
   output logic            out_last,
   output logic            done
);

   localparam int PC_W = $clog2(N_PAIRS);
   localparam int RC_W = (TW_REPEAT > 1) ? $clog2(TW_REPEAT) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_e;

   state_e              state_q, state_d;
   logic [PC_W-1:0]     pair_q, pair_d;
   logic [RC_W-1:0]     rep_q, rep_d;
   logic [TW_W-1:0]     tw_q, tw_d;
   logic [BF_LAT-1:0]   vld_q, vld_d;
   logic [BF_LAT-1:0]   lst_q, lst_d;
   logic                accept;
   logic                last_acc;

   always_comb begin
      state_d  = state_q;
      pair_d   = pair_q;
      rep_d    = rep_q;
      tw_d     = tw_q;
      accept   = (state_q == RUN) && in_valid;
      last_acc = accept && (pair_q == PC_W'(N_PAIRS - 1));
      // Shifts every cycle, so stalls become equal-length gaps at the tail.
      vld_d    = (vld_q << 1) | BF_LAT'(accept);
      lst_d    = (lst_q << 1) | BF_LAT'(last_acc);

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               pair_d  = '0;
               rep_d   = '0;
               tw_d    = TW_W'(TW_START);
            end
         end
         RUN: begin
            if (accept) begin
               pair_d = pair_q + PC_W'(1);
               if (rep_q == RC_W'(TW_REPEAT - 1)) begin
                  rep_d = '0;
                  // Explicit compare so non-power-of-two counts wrap.
                  if (tw_q == TW_W'(TW_COUNT - 1)) begin
                     tw_d = '0;
                  end else begin
                     tw_d = tw_q + TW_W'(1);
                  end
               end else begin
                  rep_d = rep_q + RC_W'(1);
               end
               if (last_acc) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Tail is emitting the final pair and nothing remains behind it.
            if (lst_q[BF_LAT-1] && (vld_d == '0)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pair_q  <= '0;
         rep_q   <= '0;
         tw_q    <= TW_W'(TW_START);
         vld_q   <= '0;
         lst_q   <= '0;
      end else begin
         state_q <= state_d;
         pair_q  <= pair_d;
         rep_q   <= rep_d;
         tw_q    <= tw_d;
         vld_q   <= vld_d;
         lst_q   <= lst_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign in_ready  = (state_q == RUN);
   assign done      = (state_q == DONE);
   assign tw_idx    = tw_q;
   assign out_valid = vld_q[BF_LAT-1];
   assign out_last  = lst_q[BF_LAT-1];

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// tb_ntt_stage_ctrl: directed checks of ntt_stage_ctrl in three parameterisations.
// A: defaults, B: 16 pairs / repeat 2 / start 3, C: 12 pairs / 6 twiddles.
module tb_ntt_stage_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic a_start, a_iv, a_busy, a_rdy, a_ov, a_ol, a_done;
   logic b_start, b_iv, b_busy, b_rdy, b_ov, b_ol, b_done;
   logic c_start, c_iv, c_busy, c_rdy, c_ov, c_ol, c_done;
   logic [2:0] a_tw, b_tw, c_tw;

   int n_assert = 0;
   int n_fail   = 0;

   logic [2:0] twl [16] = '{3, 3, 4, 4, 5, 5, 6, 6, 7, 7, 0, 0, 1, 1, 2, 2};

   ntt_stage_ctrl u_a (
      .clk(clk), .rst(rst), .start(a_start), .busy(a_busy),
      .in_valid(a_iv), .in_ready(a_rdy), .tw_idx(a_tw),
      .out_valid(a_ov), .out_last(a_ol), .done(a_done)
   );

   ntt_stage_ctrl #(.N_PAIRS(16), .TW_REPEAT(2), .TW_START(3)) u_b (
      .clk(clk), .rst(rst), .start(b_start), .busy(b_busy),
      .in_valid(b_iv), .in_ready(b_rdy), .tw_idx(b_tw),
      .out_valid(b_ov), .out_last(b_ol), .done(b_done)
   );

   ntt_stage_ctrl #(.N_PAIRS(12), .TW_COUNT(6)) u_c (
      .clk(clk), .rst(rst), .start(c_start), .busy(c_busy),
      .in_valid(c_iv), .in_ready(c_rdy), .tw_idx(c_tw),
      .out_valid(c_ov), .out_last(c_ol), .done(c_done)
   );

   function automatic logic [7:0] pk(input logic b, input logic r,
                                     input logic v, input logic l,
                                     input logic d, input logic [2:0] t);
      return {b, r, v, l, d, t};
   endfunction

   task automatic chk(input string tag, input int cyc,
                      input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc %0d: got %b expected %b (busy,rdy,ov,ol,done,tw)",
                tag, cyc, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Full default frame with in_valid held high; c counts cycles after start.
   task automatic frame_a(input string tag);
      a_start = 1'b1;
      a_iv    = 1'b1;
      step;
      a_start = 1'b0;
      for (int c = 0; c <= 266; c++) begin
         chk(tag, c, pk(a_busy, a_rdy, a_ov, a_ol, a_done, a_tw),
             pk(c <= 264, c < 256, (c >= 8) && (c <= 263), c == 263,
                c == 264, (c < 256) ? 3'(c % 8) : 3'd0));
         step;
      end
      a_iv = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      a_start = 0; a_iv = 0;
      b_start = 0; b_iv = 0;
      c_start = 0; c_iv = 0;

      for (int i = 0; i < 4; i++) begin
         a_start = 1'($urandom); a_iv = 1'($urandom);
         b_start = 1'($urandom); b_iv = 1'($urandom);
         c_start = 1'($urandom); c_iv = 1'($urandom);
         step;
         chk("rst_a", i, pk(a_busy, a_rdy, a_ov, a_ol, a_done, a_tw), 8'h00);
         chk("rst_b", i, pk(b_busy, b_rdy, b_ov, b_ol, b_done, b_tw), 8'h03);
         chk("rst_c", i, pk(c_busy, c_rdy, c_ov, c_ol, c_done, c_tw), 8'h00);
      end
      a_start = 0; a_iv = 0;
      b_start = 0; b_iv = 0;
      c_start = 0; c_iv = 0;
      rst = 1'b1;
      step;
      step;
      chk("idle_a", 0, pk(a_busy, a_rdy, a_ov, a_ol, a_done, a_tw), 8'h00);

      frame_a("frame_a");

      // Stalls: one accept every third cycle.
      b_start = 1'b1;
      b_iv    = 1'b1;
      step;
      b_start = 1'b0;
      for (int c = 0; c <= 56; c++) begin
         b_iv = (c % 3 == 0);
         chk("stall_b", c, pk(b_busy, b_rdy, b_ov, b_ol, b_done, b_tw),
             pk(c <= 54, c <= 45,
                (c >= 8) && ((c - 8) % 3 == 0) && (c <= 53),
                c == 53, c == 54, (c <= 45) ? twl[(c + 2) / 3] : 3'd3));
         step;
      end
      b_iv = 1'b0;

      // Non-power-of-two wrap with ignored start pulses in RUN/DRAIN/DONE.
      c_start = 1'b1;
      c_iv    = 1'b1;
      step;
      c_start = 1'b0;
      for (int c = 0; c <= 22; c++) begin
         c_start = (c == 3) || (c == 15) || (c == 20);
         chk("npot_c", c, pk(c_busy, c_rdy, c_ov, c_ol, c_done, c_tw),
             pk(c <= 20, c < 12, (c >= 8) && (c <= 19), c == 19,
                c == 20, (c < 12) ? 3'(c % 6) : 3'd0));
         step;
      end
      c_start = 1'b0;
      c_iv    = 1'b0;

      // Reset at accept 100.
      a_start = 1'b1;
      a_iv    = 1'b1;
      step;
      a_start = 1'b0;
      repeat (100) step;
      chk("pre_rst_run", 100, pk(a_busy, a_rdy, a_ov, a_ol, a_done, a_tw),
          pk(1, 1, 1, 0, 0, 3'd4));
      rst = 1'b0;
      #1;
      chk("rst_run_async", 0, pk(a_busy, a_rdy, a_ov, a_ol, a_done, a_tw), 8'h00);
      step;
      rst = 1'b1;
      for (int c = 0; c < 20; c++) begin
         chk("post_rst_run", c, pk(a_busy, a_rdy, a_ov, a_ol, a_done, a_tw), 8'h00);
         step;
      end

      // Reset during DRAIN.
      a_start = 1'b1;
      step;
      a_start = 1'b0;
      repeat (258) step;
      chk("pre_rst_drain", 258, pk(a_busy, a_rdy, a_ov, a_ol, a_done, a_tw),
          pk(1, 0, 1, 0, 0, 3'd0));
      rst = 1'b0;
      #1;
      chk("rst_drain_async", 0, pk(a_busy, a_rdy, a_ov, a_ol, a_done, a_tw), 8'h00);
      step;
      rst = 1'b1;
      for (int c = 0; c < 20; c++) begin
         chk("post_rst_drain", c, pk(a_busy, a_rdy, a_ov, a_ol, a_done, a_tw), 8'h00);
         step;
      end

      frame_a("frame_a_clean");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
